// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared constants and types for the instruction-fetch slice.
//   XLEN          : architectural register / address width.
//   INSTR_ALIGN   : log2 of instruction alignment in bytes (word fetches).
//   RESET_PC      : PC value handed to the PC register while reset is held.
//   fetch_entry_t : one fetched instruction tagged with the PC it came from.
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_ALIGN = 2;

    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with synchronous reset and a synchronous flush.
//   The head entry is visible on o_pop_data whenever o_empty is low
//   (show-ahead), so a consumer can look at it before popping.
//
//   Ports:
//     i_clk       clock, all updates on posedge
//     i_rst       synchronous active-high reset, empties the FIFO
//     i_push      write i_push_data at the tail (ignored when full)
//     i_push_data data to write
//     i_pop       drop the head entry (ignored when empty)
//     i_flush     empty the FIFO; overrides push and pop in the same cycle
//     o_pop_data  head entry (don't-care when empty)
//     o_full      count == DEPTH
//     o_empty     count == 0
//     o_count     number of valid entries, 0..DEPTH
//
//   DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full     = (r_count == FULL_COUNT);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset: entries are only observed when counted valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush && !i_rst) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage wrapped around an external PC register. It reads
//   the current PC, decides the next PC, issues in-order word fetches to
//   instruction memory, tags each returning word with its PC and buffers the
//   result for decode. A redirect from execute flushes everything buffered
//   and discards the responses still in flight for the old path.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high. A producer never makes valid depend on ready, and while
//   valid is high without ready its payload stays stable. The memory
//   response channel has no ready: every imem_rsp_valid cycle is consumed.
//
//   Ports:
//     CLK              clock
//     rst              synchronous active-high reset
//     PC               current PC from the PC register
//     PCNext           next PC for the PC register
//     redirect_valid   taken branch/jump from execute
//     redirect_target  redirect destination (low bits forced to alignment)
//     imem_req_valid   fetch request valid
//     imem_req_ready   memory accepts the request
//     imem_req_addr    word-aligned fetch address
//     imem_rsp_valid   in-order response valid (no backpressure)
//     imem_rsp_data    instruction word
//     dec_valid        instruction available to decode
//     dec_ready        decode accepts
//     dec_pc           PC of the presented instruction
//     dec_instr        presented instruction
//
//   D_WIDTH is expected to equal XLEN (entries use fetch_entry_t).
//   DEPTH sizes both FIFOs and caps outstanding + buffered fetches.
// ----------------------------------------------------------------------------
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int D_WIDTH = XLEN,
    parameter int DEPTH   = 4
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] PC,
    output logic [D_WIDTH-1:0] PCNext,
    input  logic               redirect_valid,
    input  logic [D_WIDTH-1:0] redirect_target,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [D_WIDTH-1:0] imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [D_WIDTH-1:0] imem_rsp_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [D_WIDTH-1:0] dec_pc,
    output logic [D_WIDTH-1:0] dec_instr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]        CREDIT_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [D_WIDTH-1:0] ALIGN_MASK   = ~D_WIDTH'((1 << INSTR_ALIGN) - 1);
    localparam logic [D_WIDTH-1:0] PC_STEP      = D_WIDTH'(1 << INSTR_ALIGN);

    // Requests accepted by memory whose response has not yet returned,
    // including those that will be thrown away after a redirect.
    logic [CW-1:0] r_outstanding;
    // How many of the outstanding responses belong to a flushed path.
    logic [CW-1:0] r_drop_cnt;

    logic          w_req_valid;
    logic          w_fire;
    logic          w_rsp_ok;
    logic          w_rsp_drop;
    logic          w_buf_push;
    logic          w_dec_fire;
    logic [CW:0]   w_inflight;

    logic [D_WIDTH-1:0] w_pend_head;
    logic               w_pend_full;
    logic               w_pend_empty;
    logic [CW-1:0]      w_pend_count;

    fetch_entry_t       w_buf_wr;
    fetch_entry_t       w_buf_head;
    logic               w_buf_full;
    logic               w_buf_empty;
    logic [CW-1:0]      w_buf_count;

    // Credit: every accepted request reserves a buffer slot until decode
    // takes it (or the redirect that made it stale drains it).
    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_buf_count};
    assign w_req_valid = !rst && !redirect_valid && (w_inflight < CREDIT_LIMIT);
    assign w_fire      = w_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp_ok    = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_drop  = w_rsp_ok && (r_drop_cnt != '0);
    // The response landing in a redirect cycle is on the old path as well.
    assign w_buf_push  = w_rsp_ok && !w_rsp_drop && !redirect_valid;

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = PC & ALIGN_MASK;

    assign dec_valid  = !rst && !w_buf_empty;
    assign w_dec_fire = dec_valid && dec_ready;
    assign dec_pc     = w_buf_head.pc;
    assign dec_instr  = w_buf_head.instr;

    always_comb begin
        w_buf_wr       = '0;
        w_buf_wr.pc    = w_pend_head;
        w_buf_wr.instr = imem_rsp_data;
    end

    always_comb begin
        PCNext = PC;
        if (rst) begin
            PCNext = D_WIDTH'(RESET_PC);
        end else if (redirect_valid) begin
            PCNext = redirect_target & ALIGN_MASK;
        end else if (w_fire) begin
            PCNext = PC + PC_STEP;
        end
    end

    // PCs of live (non-stale) requests, oldest first; matched 1:1 with the
    // responses that survive the drop counter.
    sync_fifo #(
        .WIDTH (D_WIDTH),
        .DEPTH (DEPTH)
    ) u_pending_pc (
        .i_clk       (CLK),
        .i_rst       (rst),
        .i_push      (w_fire),
        .i_push_data (PC),
        .i_pop       (w_buf_push),
        .i_flush     (redirect_valid),
        .o_pop_data  (w_pend_head),
        .o_full      (w_pend_full),
        .o_empty     (w_pend_empty),
        .o_count     (w_pend_count)
    );

    // Fetched {pc, instr} entries waiting for decode. The flush on redirect
    // lands after any same-cycle decode pop, so that handshake still counts.
    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .i_clk       (CLK),
        .i_rst       (rst),
        .i_push      (w_buf_push),
        .i_push_data (w_buf_wr),
        .i_pop       (w_dec_fire),
        .i_flush     (redirect_valid),
        .o_pop_data  (w_buf_head),
        .o_full      (w_buf_full),
        .o_empty     (w_buf_empty),
        .o_count     (w_buf_count)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding
                           + (w_fire   ? CW'(1) : CW'(0))
                           - (w_rsp_ok ? CW'(1) : CW'(0));
            // Everything still in flight after this edge is on the old path;
            // no request fires in a redirect cycle, so that is exactly the
            // post-edge outstanding count.
            if (redirect_valid) begin
                r_drop_cnt <= r_outstanding - (w_rsp_ok ? CW'(1) : CW'(0));
            end else if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    a_rsp_has_credit : assert property (@(posedge CLK) disable iff (rst)
        imem_rsp_valid |-> (r_outstanding != '0));

    a_buf_no_overflow : assert property (@(posedge CLK) disable iff (rst)
        w_buf_push |-> !w_buf_full);

    a_pend_no_overflow : assert property (@(posedge CLK) disable iff (rst)
        w_fire |-> !w_pend_full);

    a_pend_has_pc : assert property (@(posedge CLK) disable iff (rst)
        w_buf_push |-> !w_pend_empty);

    a_pend_tracks_live : assert property (@(posedge CLK) disable iff (rst)
        w_pend_count == (r_outstanding - r_drop_cnt));

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Drives fetch_stage with a modelled PC register and an in-order
//   instruction memory that returns addr ^ 32'hA5A5_0000. The reference
//   model says: decode receives, in order, exactly the requests issued since
//   the most recent redirect; a request is allowed while responses pending in
//   memory plus buffered words stay below DEPTH.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic         rst             = 1'b1;
    logic [W-1:0] pc_reg          = '0;
    logic [W-1:0] PCNext;
    logic         redirect_valid  = 1'b0;
    logic [W-1:0] redirect_target = '0;
    logic         imem_req_valid;
    logic         imem_req_ready  = 1'b0;
    logic [W-1:0] imem_req_addr;
    logic         imem_rsp_valid  = 1'b0;
    logic [W-1:0] imem_rsp_data   = '0;
    logic         dec_valid;
    logic         dec_ready       = 1'b0;
    logic [W-1:0] dec_pc;
    logic [W-1:0] dec_instr;

    fetch_stage #(
        .D_WIDTH (W),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK             (CLK),
        .rst             (rst),
        .PC              (pc_reg),
        .PCNext          (PCNext),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_pc          (dec_pc),
        .dec_instr       (dec_instr)
    );

    // Memory model: accepted requests awaiting a response, with path epoch.
    logic [W-1:0]   mem_pc_q[$];
    logic [W-1:0]   mem_data_q[$];
    int             mem_epoch_q[$];
    int             epoch    = 0;
    int             rsp_mode = 0;   // 0 hold, 1 respond every cycle, 2 random

    // Scoreboard: words in the output buffer, {pc, instr}, oldest first.
    logic [2*W-1:0] exp_q[$];

    // Observations of the last stepped cycle.
    logic [W-1:0]   got_pc_q[$];
    int             fire_cnt = 0;
    logic [W-1:0]   obs_pcnext;
    logic [W-1:0]   obs_addr;
    logic [W-1:0]   obs_dec_pc;
    logic           obs_req_valid;
    logic           obs_dec_valid;

    int n_checks = 0;
    int n_errors = 0;

    // One clock: compare combinational outputs mid-cycle, then advance the
    // model, the PC register and the memory across the rising edge.
    task automatic step(input string tag);
        logic         e_req;
        logic         e_fire;
        logic         e_dvalid;
        logic         e_dfire;
        logic [W-1:0] e_addr;
        logic [W-1:0] e_next;
        logic [W-1:0] r_pc;
        logic [W-1:0] r_data;
        int           r_ep;
        @(negedge CLK);
        e_req    = !rst && !redirect_valid && ((mem_pc_q.size() + exp_q.size()) < DEPTH);
        e_addr   = {pc_reg[W-1:2], 2'b00};
        e_fire   = e_req && imem_req_ready;
        if (rst)                 e_next = '0;
        else if (redirect_valid) e_next = {redirect_target[W-1:2], 2'b00};
        else if (e_fire)         e_next = pc_reg + 32'd4;
        else                     e_next = pc_reg;
        e_dvalid = !rst && (exp_q.size() > 0);
        e_dfire  = e_dvalid && dec_ready;

        obs_pcnext    = PCNext;
        obs_addr      = imem_req_addr;
        obs_dec_pc    = dec_pc;
        obs_req_valid = imem_req_valid;
        obs_dec_valid = dec_valid;

        n_checks++;
        if (PCNext !== e_next) begin
            n_errors++;
            $display("FAIL %s pcnext: got %h expected %h", tag, PCNext, e_next);
        end
        n_checks++;
        if (imem_req_valid !== e_req) begin
            n_errors++;
            $display("FAIL %s req_valid: got %b expected %b", tag, imem_req_valid, e_req);
        end
        if (e_req) begin
            n_checks++;
            if (imem_req_addr !== e_addr) begin
                n_errors++;
                $display("FAIL %s req_addr: got %h expected %h", tag, imem_req_addr, e_addr);
            end
        end
        n_checks++;
        if (dec_valid !== e_dvalid) begin
            n_errors++;
            $display("FAIL %s dec_valid: got %b expected %b", tag, dec_valid, e_dvalid);
        end
        if (e_dvalid) begin
            n_checks++;
            if ({dec_pc, dec_instr} !== exp_q[0]) begin
                n_errors++;
                $display("FAIL %s dec_entry: got pc=%h instr=%h expected pc=%h instr=%h",
                         tag, dec_pc, dec_instr, exp_q[0][2*W-1:W], exp_q[0][W-1:0]);
            end
        end
        if (dec_valid === 1'b1 && dec_ready) got_pc_q.push_back(dec_pc);
        if (imem_req_valid === 1'b1 && imem_req_ready) fire_cnt++;

        @(posedge CLK);
        if (rst) begin
            exp_q.delete();
            mem_pc_q.delete();
            mem_data_q.delete();
            mem_epoch_q.delete();
        end else begin
            if (e_dfire) void'(exp_q.pop_front());
            if (imem_rsp_valid) begin
                r_pc   = mem_pc_q.pop_front();
                r_data = mem_data_q.pop_front();
                r_ep   = mem_epoch_q.pop_front();
                if (r_ep == epoch && !redirect_valid) exp_q.push_back({r_pc, r_data});
            end
            if (redirect_valid) begin
                exp_q.delete();
                epoch++;
            end
            if (e_fire) begin
                mem_pc_q.push_back(pc_reg);
                mem_data_q.push_back(e_addr ^ 32'hA5A5_0000);
                mem_epoch_q.push_back(epoch);
            end
        end
        #1;
        pc_reg = e_next;
        if (mem_pc_q.size() > 0 &&
            (rsp_mode == 1 || (rsp_mode == 2 && $urandom_range(0, 1) == 1))) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data_q[0];
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        step("reset_pulse");
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        pc_reg         = 32'h0000_0040;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        rsp_mode       = 1;
        for (int i = 0; i < 2; i++) begin
            step("reset");
            n_checks++;
            if (obs_pcnext !== 32'h0 || obs_req_valid !== 1'b0 || obs_dec_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_gate: got pcnext=%h req=%b dec=%b expected 0/0/0",
                         obs_pcnext, obs_req_valid, obs_dec_valid);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        got_pc_q.delete();
        for (int i = 0; i < 16; i++) step("stream");
        n_checks++;
        if (got_pc_q.size() < 3) begin
            n_errors++;
            $display("FAIL stream_count: got %0d expected >=3", got_pc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_pc_q[i] !== 32'(4 * i)) begin
                    n_errors++;
                    $display("FAIL stream_pc%0d: got %h expected %h", i, got_pc_q[i], 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        dec_ready      = 1'b0;
        imem_req_ready = 1'b1;
        rsp_mode       = 1;
        fire_cnt       = 0;
        for (int i = 0; i < 10; i++) step("bp_fill");
        n_checks++;
        if (fire_cnt !== 4) begin
            n_errors++;
            $display("FAIL bp_fires: got %0d expected 4", fire_cnt);
        end
        n_checks++;
        if (obs_req_valid !== 1'b0 || obs_pcnext !== 32'h10) begin
            n_errors++;
            $display("FAIL bp_stall: got req=%b pcnext=%h expected 0/00000010", obs_req_valid, obs_pcnext);
        end
        n_checks++;
        if (obs_dec_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL bp_hold: got dec_pc=%h expected 00000000", obs_dec_pc);
        end
        dec_ready = 1'b1;
        got_pc_q.delete();
        for (int i = 0; i < 12; i++) step("bp_drain");
        n_checks++;
        if (got_pc_q.size() == 0 || got_pc_q[0] !== 32'h0) begin
            n_errors++;
            $display("FAIL bp_first: got %0d entries, first=%h expected 00000000",
                     got_pc_q.size(), (got_pc_q.size() > 0) ? got_pc_q[0] : 32'hx);
        end
    endtask

    task automatic test_mem_stall();
        imem_req_ready  = 1'b0;
        dec_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h20;
        step("stall_redir");
        redirect_valid = 1'b0;
        for (int i = 0; i < 8; i++) step("stall_drain");
        for (int i = 0; i < 5; i++) begin
            step("stall");
            n_checks++;
            if (obs_pcnext !== 32'h20 || obs_addr !== 32'h20 || obs_req_valid !== 1'b1 ||
                obs_dec_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold%0d: got pcnext=%h addr=%h req=%b dec=%b expected 20/20/1/0",
                         i, obs_pcnext, obs_addr, obs_req_valid, obs_dec_valid);
            end
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) step("stall_resume");
    endtask

    task automatic test_redirect_outstanding();
        do_reset();
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        rsp_mode       = 0;
        step("rd_req0");
        rsp_mode = 1;
        step("rd_req1");
        redirect_valid  = 1'b1;
        redirect_target = 32'h103;
        got_pc_q.delete();
        step("rd_redirect");
        n_checks++;
        if (obs_pcnext !== 32'h100 || obs_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_pcnext: got pcnext=%h req=%b expected 00000100/0", obs_pcnext, obs_req_valid);
        end
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) step("rd_after");
        n_checks++;
        if (got_pc_q.size() == 0 || got_pc_q[0] !== 32'h100) begin
            n_errors++;
            $display("FAIL rd_first: got %0d entries, first=%h expected 00000100",
                     got_pc_q.size(), (got_pc_q.size() > 0) ? got_pc_q[0] : 32'hx);
        end
    endtask

    task automatic test_back_to_back();
        int found;
        rsp_mode       = 2;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        for (int i = 0; i < 6; i++) step("b2b_warm");
        got_pc_q.delete();
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        step("b2b_r1");
        redirect_target = 32'h300;
        step("b2b_r2");
        redirect_valid = 1'b0;
        rsp_mode       = 1;
        for (int i = 0; i < 20; i++) step("b2b_after");
        found = 0;
        foreach (got_pc_q[i]) if (got_pc_q[i] === 32'h200) found++;
        n_checks++;
        if (found != 0) begin
            n_errors++;
            $display("FAIL b2b_stale: got %0d deliveries of pc 00000200 expected 0", found);
        end
        n_checks++;
        if (got_pc_q.size() == 0 || got_pc_q[0] !== 32'h300) begin
            n_errors++;
            $display("FAIL b2b_first: got %0d entries, first=%h expected 00000300",
                     got_pc_q.size(), (got_pc_q.size() > 0) ? got_pc_q[0] : 32'hx);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        pc_reg         = 32'hFFFF_FFFC;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        rsp_mode       = 1;
        got_pc_q.delete();
        step("wrap");
        n_checks++;
        if (obs_pcnext !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_pcnext: got %h expected 00000000", obs_pcnext);
        end
        for (int i = 0; i < 6; i++) step("wrap_after");
        n_checks++;
        if (got_pc_q.size() < 2 || got_pc_q[0] !== 32'hFFFF_FFFC || got_pc_q[1] !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_seq: got %0d entries, first=%h expected fffffffc then 00000000",
                     got_pc_q.size(), (got_pc_q.size() > 0) ? got_pc_q[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        rsp_mode = 2;
        for (int i = 0; i < 600; i++) begin
            imem_req_ready  = ($urandom_range(0, 3) != 0);
            dec_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid  = ($urandom_range(0, 15) == 0);
            redirect_target = $urandom;
            step("random");
        end
        redirect_valid = 1'b0;
        dec_ready      = 1'b1;
        rsp_mode       = 1;
        for (int i = 0; i < 12; i++) step("random_drain");
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_mem_stall();
        test_redirect_outstanding();
        test_back_to_back();
        test_pc_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
